mem_access_unit: RTL

//  MEM-stage data-memory sequencer of the LC-3b pipeline; sits between EX/MEM and mem_wb_meat.

---
 rtl/mem_access_unit_pkg.sv | 60 ++++++
 rtl/mem_access_unit_if.sv | 27 ++
 rtl/mem_access_unit_byte_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// lc3b_types: shared LC-3b types for the MEM-stage data-memory sequencer.
//   lc3b_opcode / op_* : 4-bit instruction opcodes
//   lc3b_word          : 16-bit datapath word
//   lc3b_mem_wmask     : byte enables, [1] high byte, [0] low byte
//   mem_state_t        : sequencer states IDLE, ACC, IND, DONE
package lc3b_types;

  typedef logic [3:0]  lc3b_opcode;
  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  localparam lc3b_opcode op_br   = 4'b0000;
  localparam lc3b_opcode op_add  = 4'b0001;
  localparam lc3b_opcode op_ldb  = 4'b0010;
  localparam lc3b_opcode op_stb  = 4'b0011;
  localparam lc3b_opcode op_jsr  = 4'b0100;
  localparam lc3b_opcode op_and  = 4'b0101;
  localparam lc3b_opcode op_ldw  = 4'b0110;
  localparam lc3b_opcode op_stw  = 4'b0111;
  localparam lc3b_opcode op_rti  = 4'b1000;
  localparam lc3b_opcode op_not  = 4'b1001;
  localparam lc3b_opcode op_ldi  = 4'b1010;
  localparam lc3b_opcode op_sti  = 4'b1011;
  localparam lc3b_opcode op_jmp  = 4'b1100;
  localparam lc3b_opcode op_shf  = 4'b1101;
  localparam lc3b_opcode op_lea  = 4'b1110;
  localparam lc3b_opcode op_trap = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    IND  = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  // Opcodes that need a data-memory access.
  function automatic logic is_mem_op(input lc3b_opcode op);
    case (op)
      op_ldw, op_ldb, op_ldi, op_stw, op_stb, op_sti, op_trap: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes whose first (and only) access is a write.
  function automatic logic is_direct_store(input lc3b_opcode op);
    case (op)
      op_stw, op_stb: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Opcodes that fetch a pointer first, then access through it.
  function automatic logic is_indirect_op(input lc3b_opcode op);
    case (op)
      op_ldi, op_sti: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-memory port between the MEM-stage sequencer
// (master) and the data memory (slave).
//   dmem_read/dmem_write : one-hot request strobes
//   dmem_address         : word-aligned address
//   dmem_wdata/wmask     : write data and byte enables
//   dmem_resp/dmem_rdata : completion strobe and read data
interface mem_access_unit_if;
  import lc3b_types::*;

  logic          dmem_read;
  logic          dmem_write;
  lc3b_word      dmem_address;
  lc3b_word      dmem_wdata;
  lc3b_mem_wmask dmem_wmask;
  logic          dmem_resp;
  lc3b_word      dmem_rdata;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
    input  dmem_resp, dmem_rdata
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_wmask,
    output dmem_resp, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit_byte_align.sv
// mem_byte_align: combinational byte steering for the MEM stage.
//   st_opcode/st_a0/st_data -> wdata/wmask : store lane replication and enables
//   ld_a0/rdata             -> ld_byte     : LDB byte select and extension
module mem_byte_align
  import lc3b_types::*;
#(
  parameter bit LDB_SEXT = 1'b1
) (
  input  lc3b_opcode    st_opcode,
  input  logic          st_a0,
  input  lc3b_word      st_data,
  output lc3b_word      wdata,
  output lc3b_mem_wmask wmask,
  input  logic          ld_a0,
  input  lc3b_word      rdata,
  output lc3b_word      ld_byte
);

  logic [7:0] sel_byte_s;

  // Store steering: STB replicates the low byte onto both lanes and enables one.
  always_comb begin
    if (st_opcode == op_stb) begin
      wdata = {st_data[7:0], st_data[7:0]};
      wmask = st_a0 ? 2'b10 : 2'b01;
    end else begin
      wdata = st_data;
      wmask = 2'b11;
    end
  end

  // Load extraction: pick the addressed byte and extend it to a word.
  always_comb begin
    sel_byte_s = ld_a0 ? rdata[15:8] : rdata[7:0];
    if (LDB_SEXT) begin
      ld_byte = {{8{sel_byte_s[7]}}, sel_byte_s};
    end else begin
      ld_byte = {8'h00, sel_byte_s};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory sequencer of the LC-3b pipeline.
// Runs LDW/LDB/LDI/STW/STB/STI/TRAP accesses on the dmem port and stalls the
// pipeline until they finish; other instructions pass with no added latency.
//   clk, rst_n          : clock, async active-low reset
//   req_valid, opcode   : MEM-stage instruction
//   addr, st_data       : effective address / trap vector address, store data
//   hold                : downstream stall, keeps the DONE state
//   dmem                : data-memory master port
//   mem_data            : load/TRAP result toward MEM/WB
//   stall               : freeze IF..MEM
module mem_access_unit
  import lc3b_types::*;
#(
  parameter bit LDB_SEXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  lc3b_opcode        opcode,
  input  lc3b_word          addr,
  input  lc3b_word          st_data,
  input  logic              hold,
  mem_access_unit_if.master dmem,
  output lc3b_word          mem_data,
  output logic              stall
);

  mem_state_t    state_q, state_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      st_data_q, st_data_d;
  lc3b_opcode    opcode_q, opcode_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  lc3b_word      address_q, address_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_mem_wmask wmask_q, wmask_d;
  lc3b_word      mem_data_q, mem_data_d;

  logic          is_mem_s;
  lc3b_word      al_wdata_s;
  lc3b_mem_wmask al_wmask_s;
  lc3b_word      ld_byte_s;

  assign is_mem_s = req_valid & is_mem_op(opcode);

  // Store steering looks at the incoming instruction because the request
  // registers are loaded on the IDLE->ACC edge; load extraction uses the
  // latched address bit.
  mem_byte_align #(.LDB_SEXT(LDB_SEXT)) u_align (
    .st_opcode (opcode),
    .st_a0     (addr[0]),
    .st_data   (st_data),
    .wdata     (al_wdata_s),
    .wmask     (al_wmask_s),
    .ld_a0     (addr_q[0]),
    .rdata     (dmem.dmem_rdata),
    .ld_byte   (ld_byte_s)
  );

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    st_data_d  = st_data_q;
    opcode_d   = opcode_q;
    read_d     = read_q;
    write_d    = write_q;
    address_d  = address_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: begin
        if (is_mem_s) begin
          state_d   = ACC;
          addr_d    = addr;
          st_data_d = st_data;
          opcode_d  = opcode;
          read_d    = ~is_direct_store(opcode);
          write_d   = is_direct_store(opcode);
          address_d = {addr[15:1], 1'b0};
          wdata_d   = is_direct_store(opcode) ? al_wdata_s : 16'h0000;
          wmask_d   = al_wmask_s;
        end else begin
          read_d  = 1'b0;
          write_d = 1'b0;
        end
      end
      ACC: begin
        if (dmem.dmem_resp) begin
          if (is_indirect_op(opcode_q)) begin
            // The read data is the pointer; the request stays up with the
            // new address and the memory sees it as a fresh access.
            state_d   = IND;
            read_d    = (opcode_q == op_ldi);
            write_d   = (opcode_q == op_sti);
            address_d = {dmem.dmem_rdata[15:1], 1'b0};
            wdata_d   = (opcode_q == op_sti) ? st_data_q : 16'h0000;
            wmask_d   = 2'b11;
          end else begin
            state_d = DONE;
            read_d  = 1'b0;
            write_d = 1'b0;
            case (opcode_q)
              op_ldb:          mem_data_d = ld_byte_s;
              op_ldw, op_trap: mem_data_d = dmem.dmem_rdata;
              default:         mem_data_d = mem_data_q;
            endcase
          end
        end else begin
          address_d = {addr_q[15:1], 1'b0};
        end
      end
      IND: begin
        if (dmem.dmem_resp) begin
          state_d = DONE;
          read_d  = 1'b0;
          write_d = 1'b0;
          if (opcode_q == op_ldi) begin
            mem_data_d = dmem.dmem_rdata;
          end else begin
            mem_data_d = mem_data_q;
          end
        end else begin
          state_d = IND;
        end
      end
      DONE: begin
        if (hold) begin
          state_d = DONE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // Stall: a new memory instruction stalls combinationally in IDLE so the
  // pipeline cannot run past it; reset forces it low immediately.
  always_comb begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      case (state_q)
        IDLE:     stall = is_mem_s;
        ACC, IND: stall = 1'b1;
        DONE:     stall = 1'b0;
        default:  stall = 1'b0;
      endcase
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= 16'h0000;
      st_data_q  <= 16'h0000;
      opcode_q   <= 4'h0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      address_q  <= 16'h0000;
      wdata_q    <= 16'h0000;
      wmask_q    <= 2'b00;
      mem_data_q <= 16'h0000;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      st_data_q  <= st_data_d;
      opcode_q   <= opcode_d;
      read_q     <= read_d;
      write_q    <= write_d;
      address_q  <= address_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      mem_data_q <= mem_data_d;
    end
  end

  assign dmem.dmem_read    = read_q;
  assign dmem.dmem_write   = write_q;
  assign dmem.dmem_address = address_q;
  assign dmem.dmem_wdata   = wdata_q;
  assign dmem.dmem_wmask   = wmask_q;
  assign mem_data          = mem_data_q;

endmodule
